// File: rtl/tl_mem_slave.sv
// ============================================================================
// tl_mem_slave : single-beat TileLink-UL memory responder with programmable
//                response latency. Optional macro: TL_MEM_RANGE_CHECK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tl_mem_slave #(
   parameter int                ADDR_W    = 64,
   parameter int                DATA_W    = 64,
   parameter int                DEPTH     = 1024,
   parameter int                LATENCY   = 2,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic [2:0]        a_opcode_i,
   input  logic [2:0]        a_param_i,
   input  logic [2:0]        a_size_i,
   input  logic [3:0]        a_source_i,
   input  logic [ADDR_W-1:0] a_address_i,
   input  logic [7:0]        a_mask_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic              a_valid_i,
   output logic              a_ready_o,

   output logic [2:0]        d_opcode_o,
   output logic [1:0]        d_param_o,
   output logic [2:0]        d_size_o,
   output logic [3:0]        d_source_o,
   output logic [1:0]        d_sink_o,
   output logic              d_denied_o,
   output logic [DATA_W-1:0] d_data_o,
   output logic              d_corrupt_o,
   output logic              d_valid_o,
   input  logic              d_ready_i
);

   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;

   logic              a_fire;
   logic [ADDR_W-1:0] offset;
   logic [IDX_W-1:0]  idx;
   logic              op_ok;
   logic              size_ok;
   logic              range_ok;
   logic              is_get;
   logic              is_put;
   logic              denied_req;

   logic              resp_is_data;
   logic              resp_denied;
   logic [2:0]        resp_size;
   logic [3:0]        resp_source;
   logic [DATA_W-1:0] rdata;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              unused_bits;

   assign offset = a_address_i - BASE_ADDR;
   assign idx    = offset[IDX_W+2:3];

   always_comb begin
      is_get  = (a_opcode_i == 3'd4);
      is_put  = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
      op_ok   = is_get || is_put;
      size_ok = (a_size_i <= 3'd3);
`ifdef TL_MEM_RANGE_CHECK_EN
      // Out-of-window addresses (including ones below BASE_ADDR, which wrap
      // to a huge offset) and size-misaligned addresses are refused.
      range_ok = (offset[ADDR_W-1:IDX_W+3] == '0);
      case (a_size_i)
         3'd1:    range_ok = range_ok && (a_address_i[0]   == 1'b0);
         3'd2:    range_ok = range_ok && (a_address_i[1:0] == 2'b00);
         3'd3:    range_ok = range_ok && (a_address_i[2:0] == 3'b000);
         default: range_ok = range_ok;
      endcase
`else
      range_ok = 1'b1;
`endif
      denied_req = !(op_ok && size_ok && range_ok);
   end

   assign a_ready_o = (state == S_IDLE) && !rst_i;
   assign a_fire    = a_valid_i && a_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (a_fire) state_nxt = (LATENCY == 0) ? S_RESP : S_WAIT;
         S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
         S_RESP: if (d_ready_i) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt          <= 4'd0;
         resp_is_data <= 1'b0;
         resp_denied  <= 1'b0;
         resp_size    <= 3'd0;
         resp_source  <= 4'd0;
         rdata        <= '0;
      end else if (a_fire) begin
         cnt          <= LAT_LOAD;
         resp_is_data <= is_get;
         resp_denied  <= denied_req;
         resp_size    <= a_size_i;
         resp_source  <= a_source_i;
         rdata        <= (is_get && !denied_req) ? mem[idx] : '0;
      end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   // The store has no reset; a write performed at A fire survives a later reset.
   always_ff @(posedge clk_i) begin
      if (a_fire && is_put && !denied_req) begin
         for (int b = 0; b < 8; b++) begin
            if (a_mask_i[b]) mem[idx][8*b +: 8] <= a_data_i[8*b +: 8];
         end
      end
   end

   always_comb begin
      d_valid_o   = (state == S_RESP);
      d_opcode_o  = d_valid_o ? {2'b00, resp_is_data} : 3'd0;
      d_size_o    = d_valid_o ? resp_size : 3'd0;
      d_source_o  = d_valid_o ? resp_source : 4'd0;
      d_denied_o  = d_valid_o && resp_denied;
      d_corrupt_o = d_valid_o && resp_denied && resp_is_data;
      d_data_o    = d_valid_o ? rdata : '0;
      d_param_o   = 2'd0;
      d_sink_o    = 2'd0;
   end

   assign unused_bits = ^{a_param_i, offset[2:0], offset[ADDR_W-1:IDX_W+3]};

endmodule

`default_nettype wire
